// File: rtl/uart_tx_frame_if.sv
// Parallel-side request signals and serial-side outputs of the UART transmit framer.
// The master drives the word and its framing options; the slave returns the line and busy.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ,
    output tx_out, busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, data LSB first, optional parity, stop bit.
// One bit per clock; the line and busy flag are registered from the next state.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  uart_tx_frame_if.slave bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  pen_q, pen_d;
  logic                  ptyp_q, ptyp_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  par_bit;

  // Even parity is the XOR of the word; odd parity is its complement.
  assign par_bit = ptyp_q ? ~(^data_q) : (^data_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    case (state_q)
      S_IDLE: begin
        if (bus.data_valid) begin
          state_d = S_START;
          data_d  = bus.p_data;
          pen_d   = bus.par_en;
          ptyp_d  = bus.par_typ;
        end
      end
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        if (cnt_q == LAST_BIT) begin
          state_d = pen_q ? S_PARITY : S_STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: state_d = S_STOP;
      S_STOP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it after the edge.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_d)
      S_IDLE:   busy_d = 1'b0;
      S_START:  tx_d   = 1'b0;
      S_DATA:   tx_d   = data_q[cnt_d];
      S_PARITY: tx_d   = par_bit;
      S_STOP:   tx_d   = 1'b1;
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: hand-computed frames, mid-frame reset,
// back-to-back accepts and a parity loopback through a receiver model.
module tb_uart_tx_frame;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  uart_tx_frame_if #(.DATA_WIDTH(W)) bus ();

  uart_tx_frame #(.DATA_WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Serial image of a frame, first bit on the line in the most significant used position.
  function automatic logic [15:0] frame_model(input logic [7:0] d, input logic pen,
                                              input logic typ, output int len);
    logic [15:0] f;
    f   = 16'h0;
    len = 0;
    f = {f[14:0], 1'b0}; len++;
    for (int i = 0; i < W; i++) begin
      f = {f[14:0], d[i]}; len++;
    end
    if (pen) begin
      f = {f[14:0], typ ^ (^d)}; len++;
    end
    f = {f[14:0], 1'b1}; len++;
    return f;
  endfunction

  // Called just after a negedge; returns at posedge+1 of the accept edge,
  // then scrambles the inputs to show the frame ignores later changes.
  task automatic send(input logic [7:0] d, input logic pen, input logic typ);
    bus.p_data     = d;
    bus.par_en     = pen;
    bus.par_typ    = typ;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    bus.p_data     = ~d;
    bus.par_en     = ~pen;
    bus.par_typ    = ~typ;
  endtask

  task automatic capture(input int n, output logic [15:0] bits, output int bcnt,
                         output logic idle_tx, output logic idle_busy);
    bits = 16'h0;
    bcnt = 0;
    repeat (n) begin
      @(negedge clk);
      bits = {bits[14:0], bus.tx_out};
      if (bus.busy) bcnt++;
    end
    @(negedge clk);
    idle_tx   = bus.tx_out;
    idle_busy = bus.busy;
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input logic pen,
                       input logic typ, input logic [15:0] exp_bits, input int exp_len);
    logic [15:0] bits;
    int          bcnt;
    logic        itx, ib;
    send(d, pen, typ);
    capture(exp_len, bits, bcnt, itx, ib);
    chk({tag, "_bits"}, bits, exp_bits);
    chk({tag, "_busy_len"}, bcnt, exp_len);
    chk({tag, "_idle_tx"}, itx, 1'b1);
    chk({tag, "_idle_busy"}, ib, 1'b0);
  endtask

  function automatic logic [7:0] b2b_word(input int c);
    return 8'(c * 37 + 5);
  endfunction

  initial begin
    logic [15:0] bits, fm;
    int          bcnt, len, lows, rxerr, dataerr;
    logic        itx, ib, par;
    logic [7:0]  d, rxd;
    logic        typ;
    logic        txs [0:32];
    logic        bs  [0:32];
    logic [10:0] obs_f, obs_b;

    bus.p_data     = '0;
    bus.data_valid = 1'b0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;

    #12;
    chk("reset_tx", bus.tx_out, 1'b1);
    chk("reset_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    frame("a5_even", 8'hA5, 1'b1, 1'b0, 16'b01010010101, 11);
    frame("a5_odd",  8'hA5, 1'b1, 1'b1, 16'b01010010111, 11);
    frame("01_even", 8'h01, 1'b1, 1'b0, 16'b01000000011, 11);
    frame("3c_nopar", 8'h3C, 1'b0, 1'b0, 16'b0001111001, 10);

    // Reset while data bit 3 (a zero for 8'hA5) is on the line.
    send(8'hA5, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_bit3", bus.tx_out, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", bus.tx_out, 1'b1);
    chk("mid_rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (6) begin
      @(negedge clk);
      if (!bus.tx_out || bus.busy) lows++;
    end
    chk("post_rst_idle", lows, 0);
    frame("after_rst", 8'h3C, 1'b0, 1'b0, 16'b0001111001, 10);

    // Valid held high, word changing every cycle: accepts land every 11 edges.
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    bus.p_data     = b2b_word(0);
    bus.data_valid = 1'b1;
    for (int c = 0; c < 33; c++) begin
      @(negedge clk);
      txs[c]     = bus.tx_out;
      bs[c]      = bus.busy;
      bus.p_data = b2b_word(c + 1);
    end
    bus.data_valid = 1'b0;
    for (int f = 0; f < 3; f++) begin
      obs_f = '0;
      obs_b = '0;
      for (int i = 0; i < 11; i++) begin
        obs_f = {obs_f[9:0], txs[11*f + i]};
        obs_b = {obs_b[9:0], bs[11*f + i]};
      end
      fm = frame_model(b2b_word(11*f), 1'b0, 1'b0, len);
      chk($sformatf("b2b%0d_bits", f), obs_f, {fm[9:0], 1'b1});
      chk($sformatf("b2b%0d_busy", f), obs_b, 11'b11111111110);
    end

    // Loopback into a receiver model checking parity with the same PAR_TYP.
    rxerr   = 0;
    dataerr = 0;
    for (int k = 0; k < 256; k++) begin
      d   = 8'($urandom);
      typ = 1'($urandom);
      send(d, 1'b1, typ);
      capture(11, bits, bcnt, itx, ib);
      for (int i = 0; i < W; i++) rxd[i] = bits[9 - i];
      if (((^rxd) ^ bits[1]) != typ) rxerr++;
      if (rxd != d || bits[10] != 1'b0 || bits[0] != 1'b1 || !itx || bcnt != 11) dataerr++;
    end
    chk("lb_parity_errs", rxerr, 0);
    chk("lb_data_errs", dataerr, 0);

    send(8'h5A, 1'b1, 1'b1);
    capture(11, bits, bcnt, itx, ib);
    for (int i = 0; i < W; i++) rxd[i] = bits[9 - i];
    par   = ~bits[1];
    rxerr = 0;
    if (((^rxd) ^ par) != 1'b1) rxerr++;
    chk("lb_flipped_parity", rxerr, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
